// File: rtl/microc_param.sv
// Self-sequencing microc core: fetch/exec control FSM, 16-entry register file,
// zero flag, return-address stack, and HALT/FAULT terminal states.
module microc_param #(
  parameter int DW          = 8,
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc,
  output logic            imem_rd,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic [5:0]      opcode,
  output logic            z,
  output logic            halted,
  output logic            fault,
  input  logic [3:0]      dbg_addr,
  output logic [DW-1:0]   dbg_data
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_CALL = 6'b110011;
  localparam logic [5:0] OP_RET  = 6'b110100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  function automatic logic [DW-1:0] alu_f(input logic [2:0]    op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] res;
    case (op)
      3'd0:    res = a;
      3'd1:    res = ~a;
      3'd2:    res = a + b;
      3'd3:    res = a - b;
      3'd4:    res = a & b;
      3'd5:    res = a | b;
      3'd6:    res = {DW{1'b0}} - a;
      3'd7:    res = {DW{1'b0}} - b;
      default: res = a;
    endcase
    return res;
  endfunction

  state_t          state_r, next_state_s;
  logic [PC_W-1:0] pc_r, pc_next_s, pc_inc_s, addr_s, stack_top_s;
  logic [15:0]     ir_r;
  logic            z_r, z_next_s, z_we_s;
  logic            halted_r, halted_next_s;
  logic            fault_r, fault_next_s;
  logic            imem_rd_r;
  logic            ir_load_s;
  logic [SP_W-1:0] sp_r;
  logic            push_s, pop_s;
  logic [DW-1:0]   regs_r [16];
  logic [PC_W-1:0] stack_r [STACK_DEPTH];
  logic [3:0]      rd_s, ra_s, rb_s;
  logic [DW-1:0]   a_s, b_s, alu_res_s, imm_s, reg_wdata_s;
  logic            reg_we_s;

  assign rd_s        = ir_r[11:8];
  assign ra_s        = ir_r[7:4];
  assign rb_s        = ir_r[3:0];
  assign addr_s      = ir_r[PC_W-1:0];
  assign pc_inc_s    = pc_r + PC_W'(1);
  assign imm_s       = DW'(ir_r[7:0]);
  assign stack_top_s = stack_r[IDX_W'(sp_r - SP_W'(1))];
  assign alu_res_s   = alu_f(ir_r[14:12], a_s, b_s);

  // Register-file reads; r0 is hardwired to zero on every port.
  always_comb begin
    a_s      = {DW{1'b0}};
    b_s      = {DW{1'b0}};
    dbg_data = {DW{1'b0}};
    if (ra_s != 4'd0) a_s = regs_r[ra_s];
    else              a_s = {DW{1'b0}};
    if (rb_s != 4'd0) b_s = regs_r[rb_s];
    else              b_s = {DW{1'b0}};
    if (dbg_addr != 4'd0) dbg_data = regs_r[dbg_addr];
    else                  dbg_data = {DW{1'b0}};
  end

  // Next-state, instruction decode and execute control.
  always_comb begin
    next_state_s  = state_r;
    pc_next_s     = pc_r;
    ir_load_s     = 1'b0;
    reg_we_s      = 1'b0;
    reg_wdata_s   = {DW{1'b0}};
    z_we_s        = 1'b0;
    z_next_s      = z_r;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    halted_next_s = halted_r;
    fault_next_s  = fault_r;
    case (state_r)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_load_s    = 1'b1;
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        next_state_s = ST_FETCH;
        pc_next_s    = pc_inc_s;
        if (!ir_r[15]) begin
          reg_we_s    = 1'b1;
          reg_wdata_s = alu_res_s;
          z_we_s      = 1'b1;
          z_next_s    = (alu_res_s == {DW{1'b0}});
        end else if (ir_r[15:12] == 4'b1000) begin
          reg_we_s    = 1'b1;
          reg_wdata_s = imm_s;
        end else begin
          case (ir_r[15:10])
            OP_J: pc_next_s = addr_s;
            OP_JZ: begin
              if (z_r) pc_next_s = addr_s;
              else     pc_next_s = pc_inc_s;
            end
            OP_JNZ: begin
              if (!z_r) pc_next_s = addr_s;
              else      pc_next_s = pc_inc_s;
            end
            OP_CALL: begin
              if (sp_r == SP_W'(STACK_DEPTH)) begin
                pc_next_s     = pc_r;
                fault_next_s  = 1'b1;
                halted_next_s = 1'b1;
                next_state_s  = ST_FAULT;
              end else begin
                push_s    = 1'b1;
                pc_next_s = addr_s;
              end
            end
            OP_RET: begin
              if (sp_r == SP_W'(0)) begin
                pc_next_s     = pc_r;
                fault_next_s  = 1'b1;
                halted_next_s = 1'b1;
                next_state_s  = ST_FAULT;
              end else begin
                pop_s     = 1'b1;
                pc_next_s = stack_top_s;
              end
            end
            OP_HALT: begin
              pc_next_s     = pc_r;
              halted_next_s = 1'b1;
              next_state_s  = ST_HALT;
            end
            default: pc_next_s = pc_inc_s;
          endcase
        end
      end
      ST_HALT:  next_state_s = ST_HALT;
      ST_FAULT: next_state_s = ST_FAULT;
      default:  next_state_s = ST_FETCH;
    endcase
  end

  // Architectural state; reset aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_FETCH;
      pc_r      <= {PC_W{1'b0}};
      ir_r      <= 16'h0000;
      z_r       <= 1'b0;
      halted_r  <= 1'b0;
      fault_r   <= 1'b0;
      imem_rd_r <= 1'b1;
      sp_r      <= {SP_W{1'b0}};
      for (int i = 0; i < 16; i++) regs_r[i] <= {DW{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) stack_r[i] <= {PC_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      pc_r      <= pc_next_s;
      halted_r  <= halted_next_s;
      fault_r   <= fault_next_s;
      imem_rd_r <= (next_state_s == ST_FETCH);
      if (ir_load_s) ir_r <= instr;
      if (z_we_s) z_r <= z_next_s;
      if (reg_we_s && (rd_s != 4'd0)) regs_r[rd_s] <= reg_wdata_s;
      if (push_s) begin
        stack_r[IDX_W'(sp_r)] <= pc_inc_s;
        sp_r                  <= sp_r + SP_W'(1);
      end else if (pop_s) begin
        sp_r <= sp_r - SP_W'(1);
      end
    end
  end

  assign pc      = pc_r;
  assign imem_rd = imem_rd_r;
  assign opcode  = ir_r[15:10];
  assign z       = z_r;
  assign halted  = halted_r;
  assign fault   = fault_r;

endmodule

// File: tb/tb_microc_param.sv
// Directed bench for microc_param (DW=16): a table of instructions with
// expected pc/z/register results, plus sequences for stalls, stack and halt.
module tb_microc_param;

  localparam int DW   = 16;
  localparam int PC_W = 10;
  localparam int SD   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [PC_W-1:0] pc;
  logic            imem_rd;
  logic [15:0]     instr = 16'h0000;
  logic            instr_valid = 1'b0;
  logic [5:0]      opcode;
  logic            z, halted, fault;
  logic [3:0]      dbg_addr = 4'd0;
  logic [DW-1:0]   dbg_data;

  int errors = 0;
  int checks = 0;

  microc_param #(.DW(DW), .PC_W(PC_W), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_rd(imem_rd), .instr(instr),
    .instr_valid(instr_valid), .opcode(opcode), .z(z), .halted(halted),
    .fault(fault), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     ins;
    logic [PC_W-1:0] exp_pc;
    logic            exp_z;
    logic [3:0]      reg_idx;
    logic [DW-1:0]   exp_val;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [3:0] idx, input logic [DW-1:0] exp, input string name);
    dbg_addr = idx;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic exec_instr(input logic [15:0] ins);
    logic [5:0] op;
    op = ins[15:10];
    instr = ins;
    instr_valid = 1'b1;
    tick();
    chk("imem_rd_in_exec", 32'(imem_rd), 32'd0);
    chk("opcode", 32'(opcode), 32'(op));
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_z"}, 32'(z), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_imem_rd"}, 32'(imem_rd), 32'd1);
    read_reg(4'd1, 16'h0000, {tag, "_r1"});
  endtask

  initial begin
    vecs[0]  = '{16'h8105, 10'h001, 1'b0, 4'd1, 16'h0005};  // LI r1,5
    vecs[1]  = '{16'h8203, 10'h002, 1'b0, 4'd2, 16'h0003};  // LI r2,3
    vecs[2]  = '{16'h2312, 10'h003, 1'b0, 4'd3, 16'h0008};  // ADD r3=r1+r2
    vecs[3]  = '{16'h3411, 10'h004, 1'b1, 4'd4, 16'h0000};  // SUB r4=r1-r1
    vecs[4]  = '{16'hC420, 10'h020, 1'b1, 4'd4, 16'h0000};  // JZ taken
    vecs[5]  = '{16'hC840, 10'h021, 1'b1, 4'd3, 16'h0008};  // JNZ not taken
    vecs[6]  = '{16'h1510, 10'h022, 1'b0, 4'd5, 16'hFFFA};  // NOT r5=~r1
    vecs[7]  = '{16'h4652, 10'h023, 1'b0, 4'd6, 16'h0002};  // AND r6=r5&r2
    vecs[8]  = '{16'h5712, 10'h024, 1'b0, 4'd7, 16'h0007};  // OR r7=r1|r2
    vecs[9]  = '{16'h7802, 10'h025, 1'b0, 4'd8, 16'hFFFD};  // r8=-r2
    vecs[10] = '{16'h2012, 10'h026, 1'b0, 4'd0, 16'h0000};  // ADD to r0 discarded
    vecs[11] = '{16'hC500, 10'h027, 1'b0, 4'd1, 16'h0005};  // JZ not taken
    vecs[12] = '{16'hC810, 10'h010, 1'b0, 4'd2, 16'h0003};  // JNZ taken
    vecs[13] = '{16'h9000, 10'h011, 1'b0, 4'd3, 16'h0008};  // NOP
    vecs[14] = '{16'hE000, 10'h012, 1'b0, 4'd3, 16'h0008};  // NOP
    vecs[15] = '{16'hC3FF, 10'h3FF, 1'b0, 4'd1, 16'h0005};  // J 0x3FF
    vecs[16] = '{16'h81FF, 10'h000, 1'b0, 4'd1, 16'h00FF};  // LI wraps pc
    vecs[17] = '{16'h6210, 10'h001, 1'b0, 4'd2, 16'hFF01};  // r2=-r1
    vecs[18] = '{16'h0900, 10'h002, 1'b1, 4'd9, 16'h0000};  // r9=r0
    vecs[19] = '{16'hC005, 10'h005, 1'b1, 4'd2, 16'hFF01};  // J 5
    vecs[20] = '{16'hCD00, 10'h100, 1'b1, 4'd1, 16'h00FF};  // CALL 0x100
    vecs[21] = '{16'hCE00, 10'h200, 1'b1, 4'd1, 16'h00FF};  // CALL 0x200
    vecs[22] = '{16'hD000, 10'h101, 1'b1, 4'd1, 16'h00FF};  // RET
    vecs[23] = '{16'hD000, 10'h006, 1'b1, 4'd1, 16'h00FF};  // RET

    @(negedge clk);
    do_reset();
    check_reset_state("reset");

    foreach (vecs[i]) begin
      exec_instr(vecs[i].ins);
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("v%0d_z", i), 32'(z), 32'(vecs[i].exp_z));
      chk($sformatf("v%0d_imem_rd", i), 32'(imem_rd), 32'd1);
      read_reg(vecs[i].reg_idx, vecs[i].exp_val, $sformatf("v%0d_reg", i));
    end

    // Wait states in FETCH at pc=7
    exec_instr(16'hC007);
    instr = 16'h8A5A;
    instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_imem_rd", 32'(imem_rd), 32'd1);
      chk("stall_pc", 32'(pc), 32'h007);
      read_reg(4'd10, 16'h0000, "stall_r10");
    end
    exec_instr(16'h8A5A);
    chk("stall_done_pc", 32'(pc), 32'h008);
    read_reg(4'd10, 16'h005A, "stall_done_r10");

    // Stack overflow on the fifth nested CALL
    exec_instr(16'hCC10);
    exec_instr(16'hCC20);
    exec_instr(16'hCC30);
    exec_instr(16'hCC40);
    chk("nest4_pc", 32'(pc), 32'h040);
    chk("nest4_fault", 32'(fault), 32'd0);
    exec_instr(16'hCC50);
    chk("ovf_fault", 32'(fault), 32'd1);
    chk("ovf_halted", 32'(halted), 32'd1);
    chk("ovf_pc", 32'(pc), 32'h040);
    chk("ovf_imem_rd", 32'(imem_rd), 32'd0);
    instr = 16'h8105;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ovf_hold_pc", 32'(pc), 32'h040);
      chk("ovf_hold_imem_rd", 32'(imem_rd), 32'd0);
    end
    read_reg(4'd1, 16'h00FF, "ovf_hold_r1");

    do_reset();
    check_reset_state("reset2");
    read_reg(4'd10, 16'h0000, "reset2_r10");

    // RET with empty stack
    exec_instr(16'hD000);
    chk("unf_fault", 32'(fault), 32'd1);
    chk("unf_halted", 32'(halted), 32'd1);
    chk("unf_pc", 32'(pc), 32'h000);
    chk("unf_imem_rd", 32'(imem_rd), 32'd0);

    // HALT at pc=9 is terminal
    do_reset();
    exec_instr(16'hC009);
    exec_instr(16'hFC00);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_fault", 32'(fault), 32'd0);
    instr = 16'h8105;
    instr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("halt_hold_pc", 32'(pc), 32'h009);
      chk("halt_hold_imem_rd", 32'(imem_rd), 32'd0);
    end
    read_reg(4'd1, 16'h0000, "halt_hold_r1");
    do_reset();
    check_reset_state("reset3");

    // Reset during EXEC of ADD aborts it
    exec_instr(16'h8105);
    exec_instr(16'h8203);
    instr = 16'h2312;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_z", 32'(z), 32'd0);
    chk("abort_imem_rd", 32'(imem_rd), 32'd1);
    chk("abort_opcode", 32'(opcode), 32'd0);
    read_reg(4'd3, 16'h0000, "abort_r3");
    exec_instr(16'h8305);
    chk("post_abort_pc", 32'(pc), 32'd1);
    read_reg(4'd3, 16'h0005, "post_abort_r3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
